// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: never-stalled pipeline writeback has priority,
// long-latency results queue in a small FIFO and drain when the port is idle.
module wb_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p_valid_i,
    input  logic [AW-1:0]     p_addr_i,
    input  logic [DW-1:0]     p_data_i,
    input  logic              l_valid_i,
    input  logic [AW-1:0]     l_addr_i,
    input  logic [DW-1:0]     l_data_i,
    output logic              l_ready_o,
    output logic              regwrite_o,
    output logic [AW-1:0]     writeaddr_o,
    output logic [DW-1:0]     writedata_o,
    output logic [2**AW-1:0]  pending_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             regwrite_q, regwrite_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [DW-1:0]    wdata_q, wdata_d;

    logic             push, pop, sel_vld;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic [2**AW-1:0] pend;

    assign l_ready_o = (count_q < DEPTH_C) && !rst_i;
    assign push      = l_valid_i && l_ready_o;

    always_comb begin
        pop      = !p_valid_i && (count_q != '0);
        sel_vld  = 1'b0;
        sel_addr = p_addr_i;
        sel_data = p_data_i;
        if (p_valid_i) begin
            sel_vld = 1'b1;
        end else if (pop) begin
            // a killed head still pops, but selects nothing
            sel_vld  = vld_q[rd_ptr_q];
            sel_addr = addr_q[rd_ptr_q];
            sel_data = data_q[rd_ptr_q];
        end

        vld_d = vld_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (p_valid_i && vld_q[i] && (addr_q[i] == p_addr_i)) vld_d[i] = 1'b0;
        end
        if (pop)  vld_d[rd_ptr_q] = 1'b0;
        // a same-cycle enqueue is younger than the pipeline write, so it survives
        if (push) vld_d[wr_ptr_q] = 1'b1;

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        regwrite_d = sel_vld && (sel_addr != '0);
        waddr_d    = regwrite_d ? sel_addr : waddr_q;
        wdata_d    = regwrite_d ? sel_data : wdata_q;
    end

    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pend[addr_q[i]] = 1'b1;
        end
        if (regwrite_q) pend[waddr_q] = 1'b1;
        pend[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= l_addr_i;
                data_q[wr_ptr_q] <= l_data_i;
            end
            vld_q      <= vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign regwrite_o  = regwrite_q;
    assign writeaddr_o = waddr_q;
    assign writedata_o = wdata_q;
    assign pending_o   = pend;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected register-file writes are queued in
// output order and matched against every regwrite_o pulse.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid, l_valid;
    logic [4:0]  p_addr, l_addr;
    logic [31:0] p_data, l_data;
    logic        l_ready, regwrite;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    wb_write_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .p_valid_i  (p_valid),
        .p_addr_i   (p_addr),
        .p_data_i   (p_data),
        .l_valid_i  (l_valid),
        .l_addr_i   (l_addr),
        .l_data_i   (l_data),
        .l_ready_o  (l_ready),
        .regwrite_o (regwrite),
        .writeaddr_o(writeaddr),
        .writedata_o(writedata),
        .pending_o  (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        p_valid = pv; p_addr = pa; p_data = pd;
        l_valid = lv; l_addr = la; l_data = ld;
    endtask

    // scoreboard: every write pulse must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (regwrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, writeaddr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("sb_addr", {59'd0, writeaddr}, {59'd0, e.a});
                chk("sb_data", {32'd0, writedata}, {32'd0, e.d});
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_regwrite", {63'd0, regwrite}, 0);
        chk("rst_pending", {32'd0, pending}, 0);
        chk("rst_lready", {63'd0, l_ready}, 0);
        chk("rst_wdata", {32'd0, writedata}, 0);
        #11 rst = 1'b0;
        step();
        chk("idle_lready", {63'd0, l_ready}, 1);

        // pipeline only
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("p_regwrite", {63'd0, regwrite}, 1);
        chk("p_addr", {59'd0, writeaddr}, 5);
        chk("p_data", {32'd0, writedata}, 64'hDEADBEEF);
        chk("p_pending", {32'd0, pending}, 64'h20);
        step();
        chk("p_idle_regwrite", {63'd0, regwrite}, 0);
        chk("p_idle_hold", {32'd0, writedata}, 64'hDEADBEEF);
        chk("p_idle_pending", {32'd0, pending}, 0);

        // mid-cycle reset discards a queued entry and clears outputs at once
        drive(1, 5'd6, 32'h66, 1, 5'd12, 32'hC);
        expect_wr(5'd6, 32'h66);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("mr_pending", {32'd0, pending}, 64'h1040);
        #3 rst = 1'b1;
        #1;
        chk("mr_regwrite", {63'd0, regwrite}, 0);
        chk("mr_pending0", {32'd0, pending}, 0);
        chk("mr_wdata", {32'd0, writedata}, 0);
        chk("mr_lready", {63'd0, l_ready}, 0);
        #2 rst = 1'b0;
        step();
        chk("mr_after_lready", {63'd0, l_ready}, 1);

        // contention: queued addr 7 waits behind three pipeline writes
        expect_wr(5'd1, 32'h101);
        expect_wr(5'd2, 32'h102);
        expect_wr(5'd3, 32'h103);
        expect_wr(5'd7, 32'h11);
        drive(0, 0, 0, 1, 5'd7, 32'h11);
        step();
        chk("ct_c1_regwrite", {63'd0, regwrite}, 0);
        chk("ct_c1_pend7", {63'd0, pending[7]}, 1);
        for (int k = 1; k <= 3; k++) begin
            drive(1, 5'(k), 32'h100 + 32'(k), 0, 0, 0);
            step();
            chk("ct_wr_addr", {59'd0, writeaddr}, 64'(k));
            chk("ct_pend7", {63'd0, pending[7]}, 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("ct_c5_addr", {59'd0, writeaddr}, 7);
        chk("ct_c5_pend", {32'd0, pending}, 64'h80);
        step();
        chk("ct_c6_regwrite", {63'd0, regwrite}, 0);
        chk("ct_c6_pend", {32'd0, pending}, 0);

        // full FIFO: third offer is held until a pop frees a slot
        expect_wr(5'd20, 32'h200);
        expect_wr(5'd21, 32'h201);
        expect_wr(5'd22, 32'h202);
        expect_wr(5'd10, 32'hA0);
        expect_wr(5'd11, 32'hA1);
        expect_wr(5'd12, 32'hA2);
        drive(1, 5'd20, 32'h200, 1, 5'd10, 32'hA0);
        chk("full_rdy0", {63'd0, l_ready}, 1);
        step();
        drive(1, 5'd21, 32'h201, 1, 5'd11, 32'hA1);
        chk("full_rdy1", {63'd0, l_ready}, 1);
        step();
        chk("full_rdy2", {63'd0, l_ready}, 0);
        drive(1, 5'd22, 32'h202, 1, 5'd12, 32'hA2);
        step();
        chk("full_rdy3", {63'd0, l_ready}, 0);
        drive(0, 0, 0, 1, 5'd12, 32'hA2);
        step();
        chk("full_rdy_afterpop", {63'd0, l_ready}, 1);
        step();
        chk("full_pushpop_rdy", {63'd0, l_ready}, 1);
        chk("full_pend", {32'd0, pending}, 64'h1800);
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("full_drained_pend", {32'd0, pending}, 0);

        // fill/drain rounds to wrap pointers repeatedly
        for (int r = 0; r < 10; r++) begin
            expect_wr(5'd30, 32'(r));
            expect_wr(5'd30, 32'(r + 100));
            expect_wr(5'(r + 1), 32'h1000 + 32'(r));
            expect_wr(5'(r + 11), 32'h2000 + 32'(r));
            drive(1, 5'd30, 32'(r), 1, 5'(r + 1), 32'h1000 + 32'(r));
            step();
            drive(1, 5'd30, 32'(r + 100), 1, 5'(r + 11), 32'h2000 + 32'(r));
            step();
            chk("round_full", {63'd0, l_ready}, 0);
            drive(0, 0, 0, 0, 0, 0);
            step();
            step();
            chk("round_empty", {63'd0, l_ready}, 1);
        end
        step();

        // WAW kill: queued 9/AA is superseded by pipeline 9/BB
        expect_wr(5'd4, 32'h44);
        expect_wr(5'd9, 32'hBB);
        drive(1, 5'd4, 32'h44, 1, 5'd9, 32'hAA);
        step();
        chk("waw_pend9", {63'd0, pending[9]}, 1);
        drive(1, 5'd9, 32'hBB, 0, 0, 0);
        step();
        chk("waw_bb", {32'd0, writedata}, 64'hBB);
        chk("waw_pend_out", {32'd0, pending}, 64'h200);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("waw_idle_regwrite", {63'd0, regwrite}, 0);
        chk("waw_idle_pend", {32'd0, pending}, 0);
        chk("waw_idle_hold", {32'd0, writedata}, 64'hBB);
        step();
        chk("waw_idle2_regwrite", {63'd0, regwrite}, 0);

        // same-cycle enqueue to the pipeline's address is younger and survives
        expect_wr(5'd14, 32'hE1);
        expect_wr(5'd14, 32'hE2);
        drive(1, 5'd14, 32'hE1, 1, 5'd14, 32'hE2);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("col_pend14", {32'd0, pending}, 64'h4000);
        step();
        chk("col_second", {32'd0, writedata}, 64'hE2);
        step();
        chk("col_pend_clear", {32'd0, pending}, 0);

        // register 0 never writes and never shows pending
        drive(1, 5'd0, 32'h2, 1, 5'd0, 32'h1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("r0_regwrite", {63'd0, regwrite}, 0);
        chk("r0_pend", {32'd0, pending}, 0);
        step();
        chk("r0_pop_regwrite", {63'd0, regwrite}, 0);
        chk("r0_pop_pend", {32'd0, pending}, 0);
        expect_wr(5'd18, 32'h180);
        expect_wr(5'd18, 32'h181);
        expect_wr(5'd17, 32'h170);
        expect_wr(5'd17, 32'h171);
        drive(1, 5'd18, 32'h180, 1, 5'd17, 32'h170);
        step();
        chk("r0_cnt_one", {63'd0, l_ready}, 1);
        drive(1, 5'd18, 32'h181, 1, 5'd17, 32'h171);
        step();
        chk("r0_cnt_two", {63'd0, l_ready}, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        step();
        step();
        chk("end_regwrite", {63'd0, regwrite}, 0);
        chk("end_sb_empty", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Owns the single register-file write port (regwrite/writeaddr/writedata) and drives it from two producers:
  - the in-order pipeline writeback stage, which is never stalled;
  - the long-latency unit (load-miss/multiply), which uses a valid/ready handshake.
- Long-latency results wait in a small FIFO until the port is free.
- Publishes a pending-destination bitmap so the hazard unit can stall readers of registers not yet written.

Parameters:
- DEPTH, 2, long-latency FIFO entries (power of two, 2..8)
- AW, 5, register address width
- DW, 32, register data width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- p_valid_i  in  1  pipeline WB write request this cycle
- p_addr_i  in  AW  pipeline destination register
- p_data_i  in  DW  pipeline write data
- l_valid_i  in  1  long-latency unit offers a result
- l_addr_i  in  AW  long-latency destination register
- l_data_i  in  DW  long-latency result data
- l_ready_o  out  1  FIFO can accept this cycle
- regwrite_o  out  1  register-file write enable
- writeaddr_o  out  AW  register-file write address
- writedata_o  out  DW  register-file write data
- pending_o  out  2**AW  bit a=1: register a has an unretired write in the FIFO or in the output stage

Behaviour:
- Reset (async, immediate):
  - count, read pointer and write pointer = 0; all entry valid bits = 0.
  - regwrite_o=0, writeaddr_o=0, writedata_o=0, pending_o=0.
  - l_ready_o=0 while rst_i=1.
- l_ready_o = (count < DEPTH) and not rst_i; combinational from registered state.
- Enqueue: l_valid_i & l_ready_o at edge N.
  - Entry {addr, data, valid=1} is written at the write pointer; count increments.
  - The entry becomes poppable at cycle N+1.
  - Full blocks push even when a pop happens in the same cycle; there is no pass-through.
- Selection each cycle (priority order):
  - Pipeline first: p_valid_i=1 selects the pipeline, and the FIFO head waits.
  - Otherwise, if count>0, pop the head.
    - Valid head: it is selected.
    - Killed head: it is discarded; no write this cycle, but the pop still uses the cycle.
  - Otherwise, nothing is selected.
- Output stage (registered; 1-cycle latency):
  - A selection in cycle N gives regwrite_o=1 in cycle N+1, with the matching addr and data.
  - With no selection, regwrite_o=0 and writeaddr_o/writedata_o hold their previous values.
- Register 0: a selected write with addr 0 is consumed (popped or accepted) but gives regwrite_o=0. An enqueue to addr 0 is accepted but never sets pending_o[0].
- WAW kill:
  - Trigger: p_valid_i=1 in the same cycle that a valid FIFO entry holds the same addr.
  - Effect: that entry's valid bit clears at the edge, and its data is never written, because the later pipeline instruction wins.
  - Enqueue collision: if an enqueue in the same cycle carries that addr, the new entry is NOT killed, because it is younger.
- Simultaneous push and pop (count not full): count unchanged; both pointers advance and wrap modulo DEPTH.
- pending_o:
  - OR of one-hot(addr) over valid FIFO entries, plus one-hot(writeaddr_o) when regwrite_o=1.
  - Registered-state only; no combinational path from inputs.
- Reset mid-operation: queued entries are lost and outputs are cleared immediately. Upstream reissue is not this block's concern.
- Invariants: 0 <= count <= DEPTH; at most one register-file write per cycle; FIFO entries retire in order.

Test Plan:
- Reset then idle:
  - rst_i pulse mid-cycle -> regwrite_o=0, pending_o=0 immediately.
  - After release, l_ready_o=1.
- Pipeline only: p_valid_i=1, addr 5, data 0xDEADBEEF at cycle N -> cycle N+1: regwrite_o=1, writeaddr_o=5, writedata_o=0xDEADBEEF, pending_o[5]=1.
- Contention with stall:
  - Stimulus:
    - Cycle 0: enqueue l addr 7, data 0x11.
    - Cycles 1-3: p_valid_i=1 to addrs 1, 2, 3.
    - Cycle 4: p_valid_i=0.
  - Required response:
    - Writes to 1, 2, 3 appear in cycles 2-4.
    - Addr 7 / 0x11 appears in cycle 5.
    - pending_o[7]=1 in cycles 1-5, 0 in cycle 6.
- Full FIFO, DEPTH=2:
  - Stimulus: 3 back-to-back l_valid_i with p_valid_i held 1.
  - Required response: l_ready_o=0 after the second accept; the third is held and accepted only after a pop.
  - Check: FIFO order preserved; pointer wrap is exercised across 10 fill/drain rounds.
- WAW kill:
  - Stimulus: queue addr 9 / 0xAA, then pipeline write addr 9 / 0xBB while the entry is queued.
  - Required response: only 0xBB is ever written to 9; the killed pop gives one idle cycle with regwrite_o=0.
- Register 0: enqueue addr 0 and pipeline-write addr 0 -> regwrite_o never asserts; pending_o[0] stays 0; count returns to 0.
